// File: rtl/mda_vram_arbiter.sv
// mda_vram_arbiter: shares the single 8-bit video SRAM between display
// fetches (absolute priority) and the ISA host. Host writes are posted
// through a small FIFO plus a one-entry skid register. Host reads stall
// the bus via isa_rdy until the SRAM returns data.
module mda_vram_arbiter #(
    parameter int WFIFO_DEPTH = 4,
    parameter int AW          = 19
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic [AW-1:0] isa_addr,
    input  logic [7:0]    isa_din,
    input  logic          isa_read,
    input  logic          isa_write,
    output logic [7:0]    isa_dout,
    output logic          isa_rdy,
    input  logic          isa_op_enable,
    input  logic          pixel_read,
    input  logic [AW-1:0] pixel_addr,
    output logic [7:0]    pixel_data,
    output logic [AW-1:0] ram_a,
    output logic          ram_we_l,
    output logic [7:0]    ram_d_out,
    output logic          ram_d_oe,
    input  logic [7:0]    ram_d_in
);
    localparam int IW = $clog2(WFIFO_DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    // Kind of SRAM cycle granted in N and driven on the pins in N+1.
    typedef enum logic [1:0] {CYC_IDLE, CYC_PIX, CYC_WR, CYC_RD} cyc_t;

    cyc_t          grant_d, cyc_q;
    logic          wr_prev_q, rd_prev_q;
    logic          wr_edge, rd_edge;
    logic          rd_pend_q, rd_pend_d;
    logic [AW-1:0] rd_addr_q;
    logic          skid_vld_q, skid_vld_d, skid_load;
    logic [AW-1:0] skid_addr_q;
    logic [7:0]    skid_data_q;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW-1:0] fifo_addr_q [WFIFO_DEPTH];
    logic [7:0]    fifo_data_q [WFIFO_DEPTH];
    logic          fifo_empty, fifo_full, pop, push;
    logic [AW-1:0] push_addr;
    logic [7:0]    push_data;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [7:0]    ram_d_out_q, ram_d_out_d;
    logic          ram_we_l_q, ram_we_l_d, ram_d_oe_q, ram_d_oe_d;
    logic [7:0]    pixel_data_q, isa_dout_q;

    assign wr_edge    = isa_write & ~wr_prev_q;
    assign rd_edge    = isa_read & ~rd_prev_q;
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                        (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
    assign isa_rdy    = ~rd_pend_q & ~fifo_full & ~skid_vld_q;

    // Grant: display first, then queued writes, then a read once no write is older.
    always_comb begin
        grant_d = CYC_IDLE;
        if (pixel_read) begin
            grant_d = CYC_PIX;
        end else if (isa_op_enable && !fifo_empty) begin
            grant_d = CYC_WR;
        end else if (isa_op_enable && !skid_vld_q && rd_pend_q && (cyc_q != CYC_RD)) begin
            grant_d = CYC_RD;
        end
    end

    // FIFO push/pop and skid handling; the skid entry is older than any new edge.
    always_comb begin
        pop        = (grant_d == CYC_WR);
        push       = 1'b0;
        push_addr  = isa_addr;
        push_data  = isa_din;
        skid_load  = 1'b0;
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            if (!fifo_full || pop) begin
                push       = 1'b1;
                push_addr  = skid_addr_q;
                push_data  = skid_data_q;
                skid_load  = wr_edge;
                skid_vld_d = wr_edge;
            end
        end else if (wr_edge) begin
            if (!fifo_full || pop) begin
                push = 1'b1;
            end else begin
                skid_load  = 1'b1;
                skid_vld_d = 1'b1;
            end
        end
        wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = pop  ? rptr_q + PTR_ONE : rptr_q;
    end

    // Pending read: set on a fresh edge, cleared when its data is captured.
    always_comb begin
        rd_pend_d = rd_pend_q;
        if (cyc_q == CYC_RD) begin
            rd_pend_d = 1'b0;
        end else if (rd_edge) begin
            rd_pend_d = 1'b1;
        end
    end

    // Next SRAM pin values; ram_a and ram_d_out hold through idle cycles.
    always_comb begin
        ram_a_d     = ram_a_q;
        ram_d_out_d = ram_d_out_q;
        ram_we_l_d  = 1'b1;
        ram_d_oe_d  = 1'b0;
        case (grant_d)
            CYC_PIX: ram_a_d = pixel_addr;
            CYC_RD:  ram_a_d = rd_addr_q;
            CYC_WR: begin
                ram_a_d     = fifo_addr_q[rptr_q[IW-1:0]];
                ram_d_out_d = fifo_data_q[rptr_q[IW-1:0]];
                ram_we_l_d  = 1'b0;
                ram_d_oe_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Control state, registered SRAM pins and returned data.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_prev_q    <= 1'b0;
            rd_prev_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            skid_vld_q   <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cyc_q        <= CYC_IDLE;
            ram_a_q      <= '0;
            ram_d_out_q  <= '0;
            ram_we_l_q   <= 1'b1;
            ram_d_oe_q   <= 1'b0;
            pixel_data_q <= '0;
            isa_dout_q   <= '0;
        end else begin
            wr_prev_q   <= isa_write;
            rd_prev_q   <= isa_read;
            rd_pend_q   <= rd_pend_d;
            skid_vld_q  <= skid_vld_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cyc_q       <= grant_d;
            ram_a_q     <= ram_a_d;
            ram_d_out_q <= ram_d_out_d;
            ram_we_l_q  <= ram_we_l_d;
            ram_d_oe_q  <= ram_d_oe_d;
            if (cyc_q == CYC_PIX) pixel_data_q <= ram_d_in;
            if (cyc_q == CYC_RD)  isa_dout_q   <= ram_d_in;
        end
    end

    // Data storage: FIFO entries, skid entry and latched read address.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q[IW-1:0]] <= push_addr;
            fifo_data_q[wptr_q[IW-1:0]] <= push_data;
        end
        if (skid_load) begin
            skid_addr_q <= isa_addr;
            skid_data_q <= isa_din;
        end
        if (rd_edge && !rd_pend_q) rd_addr_q <= isa_addr;
    end

    assign ram_a      = ram_a_q;
    assign ram_we_l   = ram_we_l_q;
    assign ram_d_out  = ram_d_out_q;
    assign ram_d_oe   = ram_d_oe_q;
    assign pixel_data = pixel_data_q;
    assign isa_dout   = isa_dout_q;

endmodule
